// File: rtl/spi_dev_cfg_seq.sv
// spi_dev_cfg_seq: boot-time SPI device configurator (ID check, table writes, read-back verify)
module spi_dev_cfg_seq #(
  parameter int MOSI_W = 24,
  parameter int MISO_W = 8,
  parameter int N_ENTRIES = 10,
  parameter int TBL_AW = 7,
  parameter logic [12:0] ID_ADDR = 13'h001,
  parameter logic [7:0] ID_VAL = 8'h6A,
  parameter bit VERIFY_EN = 1'b1,
  parameter logic [12:0] SKIP_ADDR = 13'h0FF,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_start,
  output logic [TBL_AW-1:0] o_tbl_addr,
  input  logic [MOSI_W-1:0] i_tbl_data,
  output logic              o_spi_wr_cmd,
  output logic              o_spi_rd_cmd,
  output logic [MOSI_W-1:0] o_spi_wr_data,
  input  logic              i_spi_busy,
  input  logic [MISO_W-1:0] i_spi_rd_data,
  input  logic              i_spi_rd_valid,
  output logic              o_cfg_busy,
  output logic              o_cfg_done,
  output logic              o_cfg_err,
  output logic [1:0]        o_err_code,
  output logic [TBL_AW-1:0] o_err_idx
);
  localparam logic [3:0] IDLE = 4'd0, ID_RD = 4'd1, ID_WAIT = 4'd2, FETCH = 4'd3,
    FETCH_WAIT = 4'd4, WR = 4'd5, WR_WAIT = 4'd6, VFY_RD = 4'd7, VFY_WAIT = 4'd8,
    DONE = 4'd9, ERR = 4'd10;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [MOSI_W-1:0] WR_MASK = {1'b0, {(MOSI_W-1){1'b1}}};
  logic [3:0] state;
  logic [TBL_AW-1:0] idx;
  logic [2:0] retry;
  logic [TW-1:0] tmo;
  logic [MOSI_W-1:0] entry;
  logic seen, start_q;
  logic [12:0] e_addr;
  logic can_retry, tmo_hit, last, verify, start_edge;
  assign e_addr = entry[20:8];
  assign can_retry = retry < 3'(MAX_RETRY);
  assign tmo_hit = tmo == TW'(TIMEOUT_CYC - 1);
  assign last = idx == TBL_AW'(N_ENTRIES - 1);
  assign verify = VERIFY_EN && e_addr != SKIP_ADDR;
  assign start_edge = i_cfg_start & ~start_q;
  // Strobes are combinational so they can never fire while the master reports busy.
  assign o_spi_rd_cmd = ~i_spi_busy & (state == ID_RD | state == VFY_RD);
  assign o_spi_wr_cmd = ~i_spi_busy & (state == WR);
  assign o_spi_wr_data = o_spi_wr_cmd ? entry & WR_MASK :
    o_spi_rd_cmd ? MOSI_W'({1'b1, 2'b00, state == ID_RD ? ID_ADDR : e_addr, 8'h00}) : '0;
  assign o_tbl_addr = idx;
  assign o_cfg_busy = state != IDLE;
  assign o_cfg_done = state == DONE;
  // Sequencer: ID read, then fetch/write/verify each table entry with retries and timeouts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      retry <= '0;
      tmo <= '0;
      entry <= '0;
      seen <= 1'b0;
      start_q <= 1'b0;
      o_cfg_err <= 1'b0;
      o_err_code <= 2'b00;
      o_err_idx <= '0;
    end else begin
      start_q <= i_cfg_start;
      tmo <= tmo + 1'b1;
      case (state)
        IDLE: if (start_edge && !i_spi_busy) begin
          state <= ID_RD;
          idx <= '0;
          retry <= '0;
          o_cfg_err <= 1'b0;
          o_err_code <= 2'b00;
          o_err_idx <= '0;
        end
        ID_RD, VFY_RD: if (!i_spi_busy) begin
          state <= state == ID_RD ? ID_WAIT : VFY_WAIT;
          tmo <= '0;
        end
        ID_WAIT: if (tmo_hit) begin
          state <= ERR;
          o_cfg_err <= 1'b1;
          o_err_code <= 2'b11;
          o_err_idx <= idx;
        end else if (i_spi_rd_valid) begin
          if (i_spi_rd_data[7:0] == ID_VAL) begin
            state <= FETCH;
            idx <= '0;
            retry <= '0;
          end else if (can_retry) begin
            state <= ID_RD;
            retry <= retry + 1'b1;
          end else begin
            state <= ERR;
            o_cfg_err <= 1'b1;
            o_err_code <= 2'b01;
            o_err_idx <= idx;
          end
        end
        FETCH: state <= FETCH_WAIT;
        FETCH_WAIT: begin
          entry <= i_tbl_data;
          state <= WR;
        end
        WR: if (!i_spi_busy) begin
          state <= WR_WAIT;
          tmo <= '0;
          seen <= 1'b0;
        end
        WR_WAIT: begin
          seen <= seen | i_spi_busy;
          if (tmo_hit) begin
            state <= ERR;
            o_cfg_err <= 1'b1;
            o_err_code <= 2'b11;
            o_err_idx <= idx;
          end else if (seen && !i_spi_busy) begin
            state <= verify ? VFY_RD : last ? DONE : FETCH;
            idx <= verify || last ? idx : idx + 1'b1;
            retry <= verify ? retry : '0;
          end
        end
        VFY_WAIT: if (tmo_hit) begin
          state <= ERR;
          o_cfg_err <= 1'b1;
          o_err_code <= 2'b11;
          o_err_idx <= idx;
        end else if (i_spi_rd_valid) begin
          if (i_spi_rd_data[7:0] == entry[7:0]) begin
            state <= last ? DONE : FETCH;
            idx <= last ? idx : idx + 1'b1;
            retry <= '0;
          end else if (can_retry) begin
            state <= WR;
            retry <= retry + 1'b1;
          end else begin
            state <= ERR;
            o_cfg_err <= 1'b1;
            o_err_code <= 2'b10;
            o_err_idx <= idx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_dev_cfg_seq.sv
// tb_spi_dev_cfg_seq: directed table-driven bench with SPI master and config ROM models
module tb_spi_dev_cfg_seq;
  logic clk = 1'b0, rst = 1'b1, i_cfg_start = 1'b0;
  logic [6:0] o_tbl_addr;
  logic [23:0] i_tbl_data = '0;
  logic o_spi_wr_cmd, o_spi_rd_cmd;
  logic [23:0] o_spi_wr_data;
  logic i_spi_busy = 1'b0, i_spi_rd_valid = 1'b0;
  logic [7:0] i_spi_rd_data = '0;
  logic o_cfg_busy, o_cfg_done, o_cfg_err;
  logic [1:0] o_err_code;
  logic [6:0] o_err_idx;
  spi_dev_cfg_seq #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst(rst), .i_cfg_start(i_cfg_start), .o_tbl_addr(o_tbl_addr),
    .i_tbl_data(i_tbl_data), .o_spi_wr_cmd(o_spi_wr_cmd), .o_spi_rd_cmd(o_spi_rd_cmd),
    .o_spi_wr_data(o_spi_wr_data), .i_spi_busy(i_spi_busy), .i_spi_rd_data(i_spi_rd_data),
    .i_spi_rd_valid(i_spi_rd_valid), .o_cfg_busy(o_cfg_busy), .o_cfg_done(o_cfg_done),
    .o_cfg_err(o_cfg_err), .o_err_code(o_err_code), .o_err_idx(o_err_idx));
  always #5 clk = ~clk;
  // Entry 5 targets the self-clearing address; entry 2 carries a stray MSB that must be cleared.
  function automatic logic [23:0] tbl_entry(int i);
    logic [12:0] a;
    a = (i == 5) ? 13'h0FF : 13'(16 + i);
    return {(i == 2), 2'b00, a, 8'(160 + i)};
  endfunction
  function automatic logic [23:0] exp_wr(logic [12:0] a);
    return tbl_entry(a == 13'h0FF ? 5 : int'(a) - 16) & 24'h7FFFFF;
  endfunction
  logic [7:0] id_val = 8'h6A;
  int bad_n = 0;
  bit withhold = 1'b0;
  logic [12:0] fa;
  assign fa = o_spi_wr_data[20:8];
  always @(posedge clk) i_tbl_data <= tbl_entry(int'(o_tbl_addr));
  int cnt = 0, v13 = 0;
  logic pend = 1'b0;
  // SPI master: busy for three cycles after a strobe, read data returned as busy falls.
  always @(posedge clk) begin
    i_spi_rd_valid <= 1'b0;
    if (rst) begin
      i_spi_busy <= 1'b0;
      cnt <= 0;
      pend <= 1'b0;
      v13 <= 0;
    end else if (cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        i_spi_busy <= 1'b0;
        i_spi_rd_valid <= pend;
      end
    end else if (o_spi_wr_cmd || o_spi_rd_cmd) begin
      i_spi_busy <= 1'b1;
      cnt <= 3;
      pend <= o_spi_rd_cmd && !(withhold && fa != 13'h001);
      i_spi_rd_data <= fa == 13'h001 ? id_val : (fa == 13'h013 && v13 < bad_n) ? 8'h5C : fa[7:0] + 8'h90;
      if (o_spi_rd_cmd && fa == 13'h013 && v13 < bad_n) v13 <= v13 + 1;
    end
  end
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, id_cnt = 0, wr13 = 0, done_cnt = 0, bad_cnt = 0;
  int last_rd = 0, err_rise = 0;
  logic err_q = 1'b0;
  // Bus monitor: counts transactions and flags illegal strobe/frame behaviour.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    err_q <= o_cfg_err;
    if (rst) begin
      wr_cnt <= 0; rd_cnt <= 0; id_cnt <= 0; wr13 <= 0; done_cnt <= 0; bad_cnt <= 0;
    end else begin
      if (o_spi_wr_cmd) wr_cnt <= wr_cnt + 1;
      if (o_spi_wr_cmd && fa == 13'h013) wr13 <= wr13 + 1;
      if (o_spi_rd_cmd) begin
        rd_cnt <= rd_cnt + 1;
        last_rd <= cyc;
      end
      if (o_spi_rd_cmd && fa == 13'h001) id_cnt <= id_cnt + 1;
      if (o_cfg_done) done_cnt <= done_cnt + 1;
      if (o_cfg_err && !err_q) err_rise <= cyc;
      bad_cnt <= bad_cnt + int'(o_spi_wr_cmd && o_spi_rd_cmd)
        + int'(o_spi_wr_cmd && o_spi_wr_data != exp_wr(fa))
        + int'(o_spi_rd_cmd && (o_spi_wr_data[23:21] != 3'b100 || o_spi_wr_data[7:0] != 8'h00))
        + int'(!o_spi_wr_cmd && !o_spi_rd_cmd && o_spi_wr_data != 24'h0)
        + int'((o_spi_wr_cmd || o_spi_rd_cmd) && i_spi_busy);
    end
  end
  int n_chk = 0, n_err = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
  endtask
  task automatic run_to_idle(string name);
    int t = 0;
    while (!o_cfg_busy && t < 10) begin @(negedge clk); t++; end
    t = 0;
    while (o_cfg_busy && t < 5000) begin @(negedge clk); t++; end
    chk({name, "_finished"}, int'(o_cfg_busy), 0);
  endtask
  typedef struct {
    logic [7:0] id; int bad; bit wh; bit hold;
    int code; int err; int idx; int done; int wr; int rd; int ids; int w13;
  } vec_t;
  vec_t v[5];
  initial begin
    v[0] = '{8'h6A, 0, 1'b0, 1'b1, 0, 0, 0, 1, 10, 10, 1, 1};
    v[1] = '{8'h00, 0, 1'b0, 1'b0, 1, 1, 0, 0, 0, 4, 4, 0};
    v[2] = '{8'h6A, 2, 1'b0, 1'b0, 0, 0, 0, 1, 12, 12, 1, 3};
    v[3] = '{8'h6A, 4, 1'b0, 1'b0, 2, 1, 3, 0, 7, 8, 1, 4};
    v[4] = '{8'h6A, 0, 1'b1, 1'b0, 3, 1, 0, 0, 1, 2, 1, 0};
    do_reset();
    @(negedge clk);
    chk("rst_busy", int'(o_cfg_busy), 0);
    chk("rst_done", int'(o_cfg_done), 0);
    chk("rst_err", int'(o_cfg_err), 0);
    chk("rst_code", int'(o_err_code), 0);
    chk("rst_idx", int'(o_err_idx), 0);
    chk("rst_strobes", int'({o_spi_wr_cmd, o_spi_rd_cmd}), 0);
    chk("rst_wdata", int'(o_spi_wr_data), 0);
    chk("rst_taddr", int'(o_tbl_addr), 0);
    for (int i = 0; i < 5; i++) begin
      id_val = v[i].id; bad_n = v[i].bad; withhold = v[i].wh;
      do_reset();
      @(negedge clk) i_cfg_start = 1'b1;
      @(negedge clk) i_cfg_start = v[i].hold;
      run_to_idle($sformatf("v%0d", i));
      repeat (20) @(negedge clk);
      chk($sformatf("v%0d_norestart", i), int'(o_cfg_busy), 0);
      chk($sformatf("v%0d_err", i), int'(o_cfg_err), v[i].err);
      chk($sformatf("v%0d_code", i), int'(o_err_code), v[i].code);
      chk($sformatf("v%0d_idx", i), int'(o_err_idx), v[i].idx);
      chk($sformatf("v%0d_done", i), done_cnt, v[i].done);
      chk($sformatf("v%0d_writes", i), wr_cnt, v[i].wr);
      chk($sformatf("v%0d_reads", i), rd_cnt, v[i].rd);
      chk($sformatf("v%0d_idreads", i), id_cnt, v[i].ids);
      chk($sformatf("v%0d_entry3_writes", i), wr13, v[i].w13);
      chk($sformatf("v%0d_bus_violations", i), bad_cnt, 0);
      if (v[i].wh) chk("timeout_latency", err_rise - last_rd, 101);
      i_cfg_start = 1'b0;
    end
    id_val = 8'h6A; bad_n = 0; withhold = 1'b0;
    do_reset();
    @(negedge clk) i_cfg_start = 1'b1;
    @(negedge clk) i_cfg_start = 1'b0;
    repeat (15) @(negedge clk);
    i_cfg_start = 1'b1;
    @(negedge clk) i_cfg_start = 1'b0;
    run_to_idle("repulse");
    repeat (20) @(negedge clk);
    chk("repulse_idle", int'(o_cfg_busy), 0);
    chk("repulse_done", done_cnt, 1);
    chk("repulse_writes", wr_cnt, 10);
    do_reset();
    @(negedge clk) i_cfg_start = 1'b1;
    @(negedge clk) i_cfg_start = 1'b0;
    begin
      int t = 0;
      while (!o_spi_wr_cmd && t < 100) begin @(negedge clk); t++; end
      chk("midwr_strobe_seen", int'(o_spi_wr_cmd), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", int'(o_cfg_busy), 0);
    chk("midrst_strobes", int'({o_spi_wr_cmd, o_spi_rd_cmd}), 0);
    chk("midrst_wdata", int'(o_spi_wr_data), 0);
    chk("midrst_taddr", int'(o_tbl_addr), 0);
    chk("midrst_flags", int'({o_cfg_done, o_cfg_err, o_err_code, o_err_idx}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_strobes", int'({o_spi_wr_cmd, o_spi_rd_cmd}), 0);
    chk("postrst_busy", int'(o_cfg_busy), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/spi_dev_cfg_seq.md
SPI_DEV_CFG_SEQ -- requirements
Module: spi_dev_cfg_seq

Interface
REQ-001 SHALL have parameter MOSI_W, default 24, meaning SPI frame width {rw, w1w0[1:0], addr[12:0], data[7:0]}.
REQ-002 SHALL have parameter MISO_W, default 8, meaning read-data width.
REQ-003 SHALL have parameter N_ENTRIES, default 10, meaning config-table entries, 1..2**TBL_AW.
REQ-004 SHALL have parameter TBL_AW, default 7, meaning table address width.
REQ-005 SHALL have parameter ID_ADDR, default 13'h001, meaning device-ID register address.
REQ-006 SHALL have parameter ID_VAL, default 8'h6A, meaning expected device ID.
REQ-007 SHALL have parameter VERIFY_EN, default 1, meaning read-back verify after each write.
REQ-008 SHALL have parameter SKIP_ADDR, default 13'h0FF, meaning self-clearing address never verified.
REQ-009 SHALL have parameter MAX_RETRY, default 3, meaning re-attempts per ID read or entry (0..7).
REQ-010 SHALL have parameter TIMEOUT_CYC, default 65535, meaning per-transaction timeout in clk cycles.
REQ-011 SHALL have ports: clk in 1 clock; rst in 1 reset; i_cfg_start in 1 start request; o_tbl_addr out TBL_AW table address; i_tbl_data in MOSI_W table entry (valid 1 cycle after o_tbl_addr); o_spi_wr_cmd out 1 write strobe; o_spi_rd_cmd out 1 read strobe; o_spi_wr_data out MOSI_W frame; i_spi_busy in 1 master busy; i_spi_rd_data in MISO_W read data; i_spi_rd_valid in 1 read-data strobe; o_cfg_busy out 1; o_cfg_done out 1 pulse; o_cfg_err out 1; o_err_code out 2; o_err_idx out TBL_AW.
REQ-012 SHALL use one clock, clk; rst synchronous, active-high.

Function
REQ-013 SHALL start only on a registered rising edge of i_cfg_start while in IDLE and i_spi_busy low; edges at other times ignored.
REQ-014 SHALL clear o_cfg_err, o_err_code, o_err_idx on accepted start.
REQ-015 SHALL use states IDLE, ID_RD, ID_WAIT, FETCH, FETCH_WAIT, WR, WR_WAIT, VFY_RD, VFY_WAIT, DONE, ERR.
REQ-016 SHALL pulse o_spi_wr_cmd/o_spi_rd_cmd for exactly one cycle, only when i_spi_busy low; never both in one cycle; o_spi_wr_data valid in strobe cycle, zero otherwise.
REQ-017 ID_RD SHALL issue read frame {1'b1, 2'b00, ID_ADDR, 8'h00}; ID_WAIT SHALL wait for i_spi_rd_valid and compare i_spi_rd_data[7:0] to ID_VAL.
REQ-018 ID match -> FETCH with index 0; mismatch -> retry ID_RD if retries < MAX_RETRY, else ERR code 2'b01.
REQ-019 FETCH SHALL drive o_tbl_addr = index; FETCH_WAIT captures i_tbl_data next cycle.
REQ-020 WR SHALL wait for ~i_spi_busy, issue write of captured entry with bit MSB forced 0; WR_WAIT waits for i_spi_busy to rise then fall.
REQ-021 After WR_WAIT: if VERIFY_EN and entry addr != SKIP_ADDR -> VFY_RD, else next entry.
REQ-022 VFY_RD SHALL issue {1'b1, 2'b00, entry addr, 8'h00}; VFY_WAIT compares returned data to entry data[7:0].
REQ-023 Verify mismatch SHALL re-enter WR for same entry if retries < MAX_RETRY, else ERR code 2'b10, o_err_idx = index.
REQ-024 Retry counter SHALL clear on each new entry and on ID success.
REQ-025 Next entry: index == N_ENTRIES-1 -> DONE; else index+1 -> FETCH; index never wraps.
REQ-026 Timeout counter SHALL run in ID_WAIT, WR_WAIT, VFY_WAIT, clear on state entry; reaching TIMEOUT_CYC -> ERR code 2'b11, o_err_idx = index; timeout wins over same-cycle rd_valid.
REQ-027 DONE SHALL pulse o_cfg_done one cycle, then IDLE; ERR SHALL set o_cfg_err (held until next accepted start), then IDLE.
REQ-028 o_cfg_busy SHALL be high in every state except IDLE.
REQ-029 i_spi_rd_valid outside ID_WAIT/VFY_WAIT SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, index 0, retry/timeout counters 0, all outputs 0, start-edge register 0, including mid-transaction; no strobe in cycle after rst.

Verification
REQ-031 Happy path: start, ID returns 8'h6A, 10 entries verify OK -> 10 writes, 9 read-backs (SKIP_ADDR entry skipped), one o_cfg_done pulse, o_cfg_err=0.
REQ-032 ID mismatch: ID returns 8'h00 four times -> 4 ID reads, ERR, o_err_code=2'b01, no writes.
REQ-033 Verify retry: entry 3 read-back wrong twice then right -> entry 3 written 3 times, done, no error; wrong 4 times -> o_err_code=2'b10, o_err_idx=3.
REQ-034 Timeout: withhold i_spi_rd_valid in VFY_WAIT, TIMEOUT_CYC=100 -> o_err_code=2'b11 after 100 cycles.
REQ-035 Start held high / re-pulsed while busy -> no restart; rst asserted mid-write -> IDLE, outputs 0 next cycle.
